// File: rtl/tns_tx_scheduler_pkg.sv
// Shared definitions for the TNS transmit scheduler.
//
// Holds the data word width used by the TNS encoder (BLEN10), the width of
// the TNS bus, the scheduler state encoding and the default burst / stall
// limits. It also provides a small circular-increment helper that the top
// module uses to advance its round-robin pointer.
//
// Contents:
//   BLEN10                  data word width fed to the encoder
//   TNS_BUS_W               number of wires on the TNS bus (30)
//   DEFAULT_MAX_BURST       default maximum words per grant
//   DEFAULT_STALL_TIMEOUT   default owner-idle cycles before revocation
//   tnssState_e             TNSS_IDLE / TNSS_XFER
//   wrapInc()               (v + 1) mod n

package tns_tx_scheduler_pkg;

    localparam int BLEN10                = 10;
    localparam int TNS_BUS_W             = 30;
    localparam int DEFAULT_MAX_BURST     = 4;
    localparam int DEFAULT_STALL_TIMEOUT = 8;

    typedef enum logic {
        TNSS_IDLE = 1'b0,
        TNSS_XFER = 1'b1
    } tnssState_e;

    // Circular increment, used to move the round-robin pointer past the
    // requester that just released its grant.
    function automatic int unsigned wrapInc(input int unsigned v, input int unsigned n);
        return ((v + 1) >= n) ? 0 : (v + 1);
    endfunction

endpackage

// File: rtl/tns_tx_scheduler_arbiter.sv
// tns_rr_arbiter: combinational rotate-priority picker.
//
// Scans the request vector starting at ptr_i and wrapping around, and
// returns the first requester found as a one-hot grant plus its index.
// With no request, the grant is all zero and the index is 0.
//
// Ports:
//   req_i    in   N_REQ   request vector
//   ptr_i    in   IDW     requester with highest priority this cycle
//   grant_o  out  N_REQ   one-hot grant, or zero
//   idx_o    out  IDW     index of the granted requester

module tns_rr_arbiter #(
    parameter int N_REQ = 4,
    parameter int IDW   = (N_REQ > 1) ? $clog2(N_REQ) : 1
) (
    input  logic [N_REQ-1:0] req_i,
    input  logic [IDW-1:0]   ptr_i,
    output logic [N_REQ-1:0] grant_o,
    output logic [IDW-1:0]   idx_o
);

    logic [IDW:0] cand;
    logic         found;

    // Walk the requesters in priority order; the extra bit on cand lets
    // ptr + offset exceed N_REQ before it is folded back into range.
    always_comb begin
        grant_o = '0;
        idx_o   = '0;
        found   = 1'b0;
        cand    = '0;
        for (int i = 0; i < N_REQ; i++) begin
            cand = {1'b0, ptr_i} + (IDW+1)'(i);
            if (cand >= (IDW+1)'(N_REQ)) begin
                cand = cand - (IDW+1)'(N_REQ);
            end
            if (!found && req_i[cand[IDW-1:0]]) begin
                found                   = 1'b1;
                grant_o[cand[IDW-1:0]]  = 1'b1;
                idx_o                   = cand[IDW-1:0];
            end
        end
    end

endmodule

// File: rtl/tns_tx_scheduler.sv
// tns_tx_scheduler: round-robin burst scheduler in front of a shared TNS
// encoder and the 30-wire TNS bus it drives.
//
// One requester at a time owns the encoder for up to MAX_BURST words. The
// accepted word is registered into enc_datain and held there until the next
// accept, so during idle and stall cycles the encoder keeps re-encoding the
// last word and its internal history stays in step with the bus. bus_code
// only updates when a freshly accepted word has made it through the encoder,
// so idle cycles leave the bus wires untouched.
//
// Ports:
//   clock        in   1               rising-edge clock
//   rst_n        in   1               synchronous active-low reset
//   req_valid    in   N_REQ           per-requester word valid
//   req_last     in   N_REQ           last word of a burst (used on accept)
//   req_data     in   N_REQ*DATA_W    packed requester words
//   req_ready    out  N_REQ           one-hot ready to the owner, or zero
//   enc_datain   out  DATA_W          registered word to the encoder
//   enc_codeout  in   TNS_BUS_W       encoder's registered codeword
//   bus_code     out  TNS_BUS_W       codeword on the TNS bus
//   bus_valid    out  1               bus_code carries a new codeword
//   grant_id     out  IDW             current or most recent owner
//   busy         out  1               granted or a word still in flight

module tns_tx_scheduler
    import tns_tx_scheduler_pkg::*;
#(
    parameter int N_REQ         = 4,
    parameter int DATA_W        = BLEN10,
    parameter int MAX_BURST     = DEFAULT_MAX_BURST,
    parameter int STALL_TIMEOUT = DEFAULT_STALL_TIMEOUT,
    parameter int IDW           = (N_REQ > 1) ? $clog2(N_REQ) : 1
) (
    input  logic                    clock,
    input  logic                    rst_n,
    input  logic [N_REQ-1:0]        req_valid,
    input  logic [N_REQ-1:0]        req_last,
    input  logic [N_REQ*DATA_W-1:0] req_data,
    output logic [N_REQ-1:0]        req_ready,
    output logic [DATA_W-1:0]       enc_datain,
    input  logic [TNS_BUS_W-1:0]    enc_codeout,
    output logic [TNS_BUS_W-1:0]    bus_code,
    output logic                    bus_valid,
    output logic [IDW-1:0]          grant_id,
    output logic                    busy
);

    localparam int BCW = $clog2(MAX_BURST + 1);
    localparam int SCW = $clog2(STALL_TIMEOUT + 1);

    tnssState_e            state_q, state_d;
    logic [IDW-1:0]        owner_q, owner_d;
    logic [IDW-1:0]        rrPtr_q, rrPtr_d;
    logic [BCW-1:0]        burstCnt_q, burstCnt_d;
    logic [SCW-1:0]        stallCnt_q, stallCnt_d;
    logic [DATA_W-1:0]     encData_q, encData_d;
    logic                  v1_q, v1_d;
    logic                  v2_q;
    logic [TNS_BUS_W-1:0]  busCode_q;
    logic                  busValid_q;

    logic [N_REQ-1:0]      arbGrant;
    logic [IDW-1:0]        arbIdx;
    logic [N_REQ-1:0]      readyVec;
    logic [DATA_W-1:0]     ownerWord;
    logic                  ownerValid;
    logic                  ownerLast;
    logic [BCW-1:0]        burstInc;
    logic [SCW-1:0]        stallInc;

    tns_rr_arbiter #(
        .N_REQ (N_REQ),
        .IDW   (IDW)
    ) uArbiter (
        .req_i   (req_valid),
        .ptr_i   (rrPtr_q),
        .grant_o (arbGrant),
        .idx_o   (arbIdx)
    );

    // Only the owner's lane is looked at; other requesters' data and
    // last flags never reach the datapath.
    always_comb begin
        ownerWord  = '0;
        ownerValid = 1'b0;
        ownerLast  = 1'b0;
        for (int i = 0; i < N_REQ; i++) begin
            if (owner_q == IDW'(i)) begin
                ownerWord  = req_data[i*DATA_W +: DATA_W];
                ownerValid = req_valid[i];
                ownerLast  = req_last[i];
            end
        end
    end

    assign burstInc = burstCnt_q + BCW'(1);
    assign stallInc = stallCnt_q + SCW'(1);

    // Next-state logic. IDLE only arbitrates; the winner starts accepting
    // one cycle later in XFER. Any release (last word, burst cap or stall
    // timeout) moves the pointer just past the owner for fairness.
    always_comb begin
        state_d    = state_q;
        owner_d    = owner_q;
        rrPtr_d    = rrPtr_q;
        burstCnt_d = burstCnt_q;
        stallCnt_d = stallCnt_q;
        encData_d  = encData_q;
        v1_d       = 1'b0;
        readyVec   = '0;
        case (state_q)
            TNSS_IDLE: begin
                if (|arbGrant) begin
                    owner_d    = arbIdx;
                    burstCnt_d = '0;
                    stallCnt_d = '0;
                    state_d    = TNSS_XFER;
                end
            end
            TNSS_XFER: begin
                readyVec = N_REQ'(1) << owner_q;
                if (ownerValid) begin
                    encData_d  = ownerWord;
                    v1_d       = 1'b1;
                    burstCnt_d = burstInc;
                    stallCnt_d = '0;
                    if (ownerLast || (burstInc == BCW'(MAX_BURST))) begin
                        state_d = TNSS_IDLE;
                        rrPtr_d = IDW'(wrapInc(int'(owner_q), N_REQ));
                    end
                end else begin
                    stallCnt_d = stallInc;
                    if (stallInc == SCW'(STALL_TIMEOUT)) begin
                        state_d = TNSS_IDLE;
                        rrPtr_d = IDW'(wrapInc(int'(owner_q), N_REQ));
                    end
                end
            end
            default: begin
                state_d = TNSS_IDLE;
            end
        endcase
    end

    // State, counters and the three-stage delivery pipeline. v1 marks a
    // fresh word at the encoder input, v2 a fresh codeword at its output;
    // bus_code is only reloaded behind v2 so replays never touch the bus.
    always_ff @(posedge clock) begin
        if (!rst_n) begin
            state_q    <= TNSS_IDLE;
            owner_q    <= '0;
            rrPtr_q    <= '0;
            burstCnt_q <= '0;
            stallCnt_q <= '0;
            encData_q  <= '0;
            v1_q       <= 1'b0;
            v2_q       <= 1'b0;
            busCode_q  <= '0;
            busValid_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            owner_q    <= owner_d;
            rrPtr_q    <= rrPtr_d;
            burstCnt_q <= burstCnt_d;
            stallCnt_q <= stallCnt_d;
            encData_q  <= encData_d;
            v1_q       <= v1_d;
            v2_q       <= v1_q;
            busValid_q <= v2_q;
            if (v2_q) begin
                busCode_q <= enc_codeout;
            end
        end
    end

    // Ready is masked by reset so no handshake can appear to complete in a
    // cycle whose edge is going to discard it.
    assign req_ready  = rst_n ? readyVec : '0;
    assign enc_datain = encData_q;
    assign bus_code   = busCode_q;
    assign bus_valid  = busValid_q;
    assign grant_id   = owner_q;
    assign busy       = (state_q == TNSS_XFER) | v1_q | v2_q | busValid_q;

endmodule

// File: tb/tb_tns_tx_scheduler.sv
// Testbench for tns_tx_scheduler.
//
// A stand-in TNS encoder (registered, history = previous datain) closes the
// enc_* loop. Requesters are fed from per-lane word buffers. A reference
// model tracks grants, in-flight codewords (as due-cycle/codeword pairs) and
// the bus value, and every cycle the DUT outputs are compared against it.
// Directed scenarios are followed by a randomized phase.

module tb_tns_tx_scheduler;

    localparam int N   = 4;
    localparam int DW  = 10;
    localparam int MB  = 4;
    localparam int TO  = 8;
    localparam int IDW = 2;

    logic            clock = 1'b0;
    logic            rst_n;
    logic [N-1:0]    req_valid;
    logic [N-1:0]    req_last;
    logic [N*DW-1:0] req_data;
    logic [N-1:0]    req_ready;
    logic [DW-1:0]   enc_datain;
    logic [29:0]     enc_codeout = '0;
    logic [29:0]     bus_code;
    logic            bus_valid;
    logic [IDW-1:0]  grant_id;
    logic            busy;

    always #5 clock = ~clock;

    tns_tx_scheduler #(
        .N_REQ         (N),
        .DATA_W        (DW),
        .MAX_BURST     (MB),
        .STALL_TIMEOUT (TO)
    ) dut (
        .clock       (clock),
        .rst_n       (rst_n),
        .req_valid   (req_valid),
        .req_last    (req_last),
        .req_data    (req_data),
        .req_ready   (req_ready),
        .enc_datain  (enc_datain),
        .enc_codeout (enc_codeout),
        .bus_code    (bus_code),
        .bus_valid   (bus_valid),
        .grant_id    (grant_id),
        .busy        (busy)
    );

    // Golden encoding: depends on the word and on the previous word sent.
    function automatic logic [29:0] tnsEncode(input logic [9:0] d, input logic [9:0] p);
        return {d ^ p, d ^ {p[4:0], p[9:5]}, d};
    endfunction

    // Stand-in for the external encoder: one register stage, history is
    // whatever datain it saw on the previous edge.
    logic [9:0] encPrev = '0;
    always @(posedge clock) begin
        enc_codeout <= tnsEncode(enc_datain, encPrev);
        encPrev     <= enc_datain;
    end

    int nChecks = 0;
    int nFails  = 0;

    task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
        nChecks++;
        if (got !== exp) begin
            nFails++;
            $display("[TB] FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Requester word buffers: {data, last}
    logic [10:0] rbuf [N][64];
    int          rHead [N];
    int          rTail [N];
    bit          gateRandom = 1'b0;

    task automatic pushItem(input int r, input logic [9:0] d, input logic l);
        if (rTail[r] - rHead[r] < 60) begin
            rbuf[r][rTail[r] % 64] = {d, l};
            rTail[r]++;
        end
    endtask

    function automatic bit anyPending();
        bit p = 1'b0;
        for (int i = 0; i < N; i++) if (rTail[i] != rHead[i]) p = 1'b1;
        return p;
    endfunction

    // Drive each requester from the head of its buffer; idle lanes carry
    // random garbage so any sampling of a non-owner lane shows up.
    task automatic applyStimulus();
        for (int i = 0; i < N; i++) begin
            if ((rTail[i] != rHead[i]) && (!gateRandom || ($urandom_range(0, 3) != 0))) begin
                req_valid[i]         = 1'b1;
                req_data[i*DW +: DW] = rbuf[i][rHead[i] % 64][10:1];
                req_last[i]          = rbuf[i][rHead[i] % 64][0];
            end else begin
                req_valid[i]         = 1'b0;
                req_data[i*DW +: DW] = DW'($urandom);
                req_last[i]          = 1'($urandom);
            end
        end
    endtask

    // Reference model
    typedef struct packed {
        int          due;
        logic [29:0] code;
    } flight_t;

    flight_t     inflight[$];
    int          grantLog[$];
    int          cyc        = 0;
    bit          mGranted   = 1'b0;
    int          mOwner     = 0;
    int          mPtr       = 0;
    int          mBurst     = 0;
    int          mStall     = 0;
    logic [9:0]  mWord      = '0;
    logic [9:0]  mPrevWord  = '0;
    logic [29:0] mBusCode   = '0;
    logic [N-1:0] prevDutReady = '0;

    function automatic int logAt(input int idx);
        return (idx < grantLog.size()) ? grantLog[idx] : -1;
    endfunction

    // One clock cycle: compare outputs mid-cycle, advance the model with
    // the inputs the DUT will sample on the coming edge, then cross it.
    task automatic stepCycle();
        logic [N-1:0] expReady;
        logic         expValid;
        logic         expBusy;
        logic [9:0]   w;
        int           pick;
        flight_t      f;
        @(negedge clock);
        expReady = (rst_n && mGranted) ? N'(1 << mOwner) : '0;
        expValid = 1'b0;
        expBusy  = mGranted;
        foreach (inflight[k]) begin
            if (inflight[k].due == cyc) begin
                expValid = 1'b1;
                mBusCode = inflight[k].code;
            end
            if (inflight[k].due >= cyc && inflight[k].due <= cyc + 2) expBusy = 1'b1;
        end
        checkOutput("req_ready",  32'(req_ready),  32'(expReady));
        checkOutput("bus_valid",  32'(bus_valid),  32'(expValid));
        checkOutput("bus_code",   32'(bus_code),   32'(mBusCode));
        checkOutput("grant_id",   32'(grant_id),   32'(mOwner));
        checkOutput("enc_datain", 32'(enc_datain), 32'(mWord));
        checkOutput("busy",       32'(busy),       32'(expBusy));
        if (req_ready != '0 && prevDutReady == '0) grantLog.push_back(int'(grant_id));
        prevDutReady = req_ready;
        while (inflight.size() > 0 && inflight[0].due <= cyc) void'(inflight.pop_front());

        if (!rst_n) begin
            mGranted  = 1'b0;
            mOwner    = 0;
            mPtr      = 0;
            mBurst    = 0;
            mStall    = 0;
            mWord     = '0;
            mPrevWord = '0;
            mBusCode  = '0;
            inflight.delete();
        end else if (!mGranted) begin
            pick = -1;
            for (int i = 0; i < N; i++) begin
                if (pick < 0 && req_valid[(mPtr + i) % N]) pick = (mPtr + i) % N;
            end
            if (pick >= 0) begin
                mGranted = 1'b1;
                mOwner   = pick;
                mBurst   = 0;
                mStall   = 0;
            end
        end else if (req_valid[mOwner]) begin
            w         = req_data[mOwner*DW +: DW];
            f.due     = cyc + 3;
            f.code    = tnsEncode(w, mPrevWord);
            inflight.push_back(f);
            mPrevWord = w;
            mWord     = w;
            mBurst++;
            mStall    = 0;
            rHead[mOwner]++;
            if (req_last[mOwner] || mBurst == MB) begin
                mGranted = 1'b0;
                mPtr     = (mOwner + 1) % N;
            end
        end else begin
            mStall++;
            if (mStall == TO) begin
                mGranted = 1'b0;
                mPtr     = (mOwner + 1) % N;
            end
        end
        cyc++;
        @(posedge clock);
        #1;
    endtask

    task automatic runCycles(input int n);
        for (int i = 0; i < n; i++) begin
            applyStimulus();
            stepCycle();
        end
    endtask

    task automatic runUntilQuiet(input int budget);
        int n = 0;
        while ((anyPending() || mGranted || inflight.size() > 0) && n < budget) begin
            applyStimulus();
            stepCycle();
            n++;
        end
        checkOutput("quiet_in_budget", 32'(n < budget), 32'd1);
    endtask

    task automatic resetDut(input int n);
        rst_n = 1'b0;
        runCycles(n);
        rst_n = 1'b1;
    endtask

    initial begin
        #1_000_000;
        $display("[TB] FAIL watchdog: simulation did not finish");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        logic [29:0] expCode;
        logic [9:0]  w2;
        int          base;
        int          n;

        for (int i = 0; i < N; i++) begin
            rHead[i] = 0;
            rTail[i] = 0;
        end
        req_valid = '0;
        req_last  = '0;
        req_data  = '0;

        // Reset with every requester asking, then first grant to req0
        for (int i = 0; i < N; i++) pushItem(i, 10'(i + 1), 1'b1);
        resetDut(3);
        applyStimulus();
        stepCycle();
        applyStimulus();
        #3;
        checkOutput("first_grant", 32'(req_ready), 32'h1);
        stepCycle();
        runUntilQuiet(100);

        // Single word on req2, bus holds afterwards
        expCode = tnsEncode(10'd5, mPrevWord);
        pushItem(2, 10'd5, 1'b1);
        runUntilQuiet(50);
        runCycles(4);
        checkOutput("single_code", 32'(bus_code), 32'(expCode));

        // Burst cap: six unterminated words from a sole requester
        base = grantLog.size();
        for (int k = 0; k < 6; k++) pushItem(1, 10'($urandom), 1'b0);
        runUntilQuiet(100);
        checkOutput("cap_grants", 32'(grantLog.size() - base), 32'd2);
        checkOutput("cap_owner0", 32'(logAt(base)),     32'd1);
        checkOutput("cap_owner1", 32'(logAt(base + 1)), 32'd1);

        // Fairness from a fresh pointer
        resetDut(2);
        base = grantLog.size();
        for (int i = 0; i < N; i++) begin
            pushItem(i, 10'($urandom), 1'b0);
            pushItem(i, 10'($urandom), 1'b1);
        end
        pushItem(0, 10'($urandom), 1'b0);
        pushItem(0, 10'($urandom), 1'b1);
        runUntilQuiet(200);
        checkOutput("fair_g0", 32'(logAt(base)),     32'd0);
        checkOutput("fair_g1", 32'(logAt(base + 1)), 32'd1);
        checkOutput("fair_g2", 32'(logAt(base + 2)), 32'd2);
        checkOutput("fair_g3", 32'(logAt(base + 3)), 32'd3);
        checkOutput("fair_g4", 32'(logAt(base + 4)), 32'd0);

        // Stall timeout on req3 with req0 waiting
        base = grantLog.size();
        pushItem(3, 10'h2a5, 1'b0);
        n = 0;
        while (!(mGranted && mOwner == 3) && n < 20) begin
            applyStimulus();
            stepCycle();
            n++;
        end
        checkOutput("stall_granted", 32'(n < 20), 32'd1);
        pushItem(0, 10'h11b, 1'b1);
        runUntilQuiet(100);
        checkOutput("stall_g0", 32'(logAt(base)),     32'd3);
        checkOutput("stall_g1", 32'(logAt(base + 1)), 32'd0);

        // Replay consistency: same word twice around an idle gap
        expCode = tnsEncode(10'd7, mPrevWord);
        pushItem(0, 10'd7, 1'b1);
        runUntilQuiet(50);
        checkOutput("replay_first", 32'(bus_code), 32'(expCode));
        runCycles(5);
        pushItem(0, 10'd7, 1'b1);
        runUntilQuiet(50);
        checkOutput("replay_second", 32'(bus_code), 32'(tnsEncode(10'd7, 10'd7)));

        // Reset on the second word of a burst
        w2 = 10'h0f3;
        pushItem(2, 10'h155, 1'b0);
        pushItem(2, w2, 1'b0);
        pushItem(2, 10'h3c1, 1'b1);
        n = 0;
        while (!(mGranted && mBurst == 1) && n < 20) begin
            applyStimulus();
            stepCycle();
            n++;
        end
        checkOutput("midrst_reached", 32'(n < 20), 32'd1);
        rst_n = 1'b0;
        applyStimulus();
        stepCycle();
        checkOutput("midrst_code",  32'(bus_code),   32'd0);
        checkOutput("midrst_valid", 32'(bus_valid),  32'd0);
        checkOutput("midrst_ready", 32'(req_ready),  32'd0);
        checkOutput("midrst_data",  32'(enc_datain), 32'd0);
        checkOutput("midrst_busy",  32'(busy),       32'd0);
        applyStimulus();
        stepCycle();
        rst_n = 1'b1;
        n = 0;
        while (!bus_valid && n < 20) begin
            applyStimulus();
            stepCycle();
            n++;
        end
        checkOutput("postrst_code", 32'(bus_code), 32'(tnsEncode(w2, 10'd0)));
        runUntilQuiet(100);

        // Randomized traffic with gapped valids
        gateRandom = 1'b1;
        for (int c = 0; c < 400; c++) begin
            if ($urandom_range(0, 3) == 0) begin
                pushItem(int'($urandom_range(0, N - 1)), 10'($urandom), ($urandom_range(0, 2) == 0));
            end
            applyStimulus();
            stepCycle();
        end
        runUntilQuiet(2000);
        gateRandom = 1'b0;

        $display("== %0d vectors applied, %0d miscompares ==", nChecks, nFails);
        $finish;
    end

endmodule

// File: doc/tns_tx_scheduler.md
Name: tns_tx_scheduler

Overview:
- Round-robin scheduler that shares one TNS_encoder_30 instance, and the 30-wire TNS bus it drives, among N_REQ requesters.
- Each grant is burst-based. During idle and stall cycles the block replays the last accepted data word into the encoder, so the encoder's r_bit memory stays consistent with the last transmitted codeword. The bus holds its value, so idle cycles cause zero wire transitions.
- Sits between the link-layer source FIFOs and the encoder, which is instantiated externally; the block connects to it through the enc_* ports.

Parameters:
- N_REQ, 4, number of requesters (2..8).
- DATA_W, `BLEN10, data word width; the value comes from TNS.vh.
- MAX_BURST, 4, maximum words per grant (1..15).
- STALL_TIMEOUT, 8, consecutive owner-not-valid cycles before a grant is revoked (1..255).

Ports:
- clock  in  1  single clock; every flop is rising-edge.
- rst_n  in  1  synchronous, active-low reset.
- req_valid  in  N_REQ  per-requester word valid.
- req_last  in  N_REQ  marks the final word of a burst; sampled only on accept.
- req_data  in  N_REQ*DATA_W  packed words; requester i occupies bits [i*DATA_W +: DATA_W].
- req_ready  out  N_REQ  one-hot, or all zero.
- enc_datain  out  DATA_W  registered word to the encoder's datain.
- enc_codeout  in  30  the encoder's registered codeout.
- bus_code  out  30  codeword driven onto the TNS bus.
- bus_valid  out  1  high in cycles where bus_code carries a new codeword.
- grant_id  out  $clog2(N_REQ)  current or most recent owner.
- busy  out  1  high in XFER state or while the pipeline holds a valid word.

Behaviour:
- Reset: synchronous, active-low.
  - While rst_n=0: state=IDLE, rr_ptr=0, grant_id=0, enc_datain=0, bus_code=0, bus_valid=0, req_ready=0, burst and stall counters=0, pipeline valids=0.
  - rst_n must stay low for at least 2 cycles. This lets the encoder's r_bit settle to the code of 0, which is all zeros.
  - Asserting reset mid-burst aborts it immediately; words in flight are dropped and bus_code returns to 0.
- FSM, IDLE:
  - req_ready=0.
  - If any req_valid is set, pick the first requester at or after rr_ptr in circular order. Latch it as owner and grant_id, clear the counters, and go to XFER next cycle.
  - No request accepts a word in the same cycle as arbitration.
- FSM, XFER:
  - req_ready[owner]=1; all other bits are 0.
  - Accept = req_valid[owner] & req_ready[owner].
  - On accept: enc_datain<=word, v1<=1, burst_cnt+1, stall_cnt<=0.
  - Release when the accepted word has req_last=1, or when burst_cnt reaches MAX_BURST after this accept.
  - No accept: enc_datain keeps its value (replay), v1<=0, stall_cnt+1. Release when stall_cnt reaches STALL_TIMEOUT.
  - On release: rr_ptr<=owner+1 mod N_REQ, go to IDLE, req_ready drops on the next cycle.
  - A grant never lasts more than MAX_BURST accepts.
- Pipeline:
  - v2<=v1 tracks the encoder's register stage.
  - When v2=1: bus_code<=enc_codeout and bus_valid<=1. Otherwise bus_code holds and bus_valid<=0.
  - Latency: a word accepted in cycle t gives bus_valid=1 in cycle t+3, carrying its codeword.
  - Back-to-back accepts give back-to-back bus_valid. Order is preserved.
- Replay invariant: enc_datain changes only on accept, so the encoder re-encodes the last word every idle cycle.
- busy = (state==XFER) | v1 | v2 | bus_valid.
- Boundaries:
  - Owner drops req_valid mid-burst: the burst continues when valid returns before timeout.
  - req_last arriving on the MAX_BURST-th word: a single release.
  - Only one requester active: it is re-granted after exactly one IDLE cycle.
  - req_data of a non-owner is never sampled.
  - Bits above the codeable range are not checked; they are the caller's responsibility.

Decomposition:
- Shared header TNS.vh supplies BLEN10, the TNS constants and the bus width (30).
- Add to the same header: TNSS_IDLE/TNSS_XFER state encodings, plus default MAX_BURST and STALL_TIMEOUT.
- One natural sub-module: tns_rr_arbiter. It is a combinational, N_REQ-parameterised rotate-priority picker that takes the request vector and rr_ptr and returns a one-hot grant and the grant index.
- Counters, FSM and pipeline stay in the top module.

Test Plan:
- Reset and settle: rst_n low for 3 cycles with req_valid=4'b1111 -> req_ready=0, bus_code=0, bus_valid=0. After release, the first grant goes to req0, with req_ready=4'b0001 in the second cycle.
- Single word: req2 sends data 5 with req_last=1 -> accepted in cycle t, bus_valid=1 in cycle t+3 with bus_code equal to the golden TNS encoding of 5, rr_ptr=3. After that, bus_code holds its value with zero toggles while idle.
- Burst cap: req1 streams 6 words with req_last=0 and MAX_BURST=4 -> exactly 4 accepts, release, 1 IDLE cycle, re-grant to req1 (sole requester), remaining 2 words delivered in order.
- Fairness: all four requesters hold 2-word bursts -> grant order 0,1,2,3,0; no requester is granted twice before the others.
- Stall and timeout: req3 sends 1 word, then drops valid for 8 cycles -> enc_datain is unchanged, bus_valid=0 throughout, grant revoked after the 8th stall cycle, and req0 (pending) is granted next.
- Replay consistency: send 7, idle 5 cycles, send 7 again -> both bus codewords match the golden model. This includes r_bit history, with the idle replays treated as invisible.
- Mid-burst reset: assert reset on the 2nd word of a burst -> all outputs are 0 on the next edge, and the first post-reset codeword matches the model with r_bit=0.
